// File: rtl/spi_slave_if_if.sv
// ---------------------------------------------------------------------------
// spi_slave_if_if
// Purpose : groups the SPI pin signals and the RAM-side command/read-back
//           signals of the SPI slave front end into one bundle.
// Signals : SS_n     - slave select, active low (master -> slave)
//           MOSI     - serial data in, MSB first (master -> slave)
//           MISO     - serial data out, MSB first (slave -> master)
//           rx_data  - assembled command word towards the RAM (slave out)
//           rx_valid - one-cycle strobe qualifying rx_data (slave out)
//           tx_data  - read-back byte from the RAM (slave in)
//           tx_valid - tx_data valid level (slave in)
// Modports: slave  - view used by spi_slave_if
//           master - view used by whatever drives the pins and the RAM side
// ---------------------------------------------------------------------------
interface spi_slave_if_if #(
  parameter int RX_WIDTH = 10,
  parameter int TX_WIDTH = 8
);

  logic                SS_n;
  logic                MOSI;
  logic                MISO;
  logic [RX_WIDTH-1:0] rx_data;
  logic                rx_valid;
  logic [TX_WIDTH-1:0] tx_data;
  logic                tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_slave_if.sv
// ---------------------------------------------------------------------------
// spi_slave_if
// Purpose : SPI slave front end in front of the single-port RAM. A frame is
//           the interval during which SS_n is low. The first MOSI bit of a
//           frame is a command bit that picks the frame type, the next
//           RX_WIDTH bits are assembled MSB first into rx_data and flagged
//           with a one-cycle rx_valid. In a read-data frame the byte offered
//           on tx_data (qualified by tx_valid) is shifted out on MISO, MSB
//           first. The SPI clock is the system clock, single domain.
// Ports   : clk - system/SPI clock, rising edge
//           rst - asynchronous active-high reset
//           bus - spi_slave_if_if.slave (SS_n, MOSI, MISO, rx_data,
//                 rx_valid, tx_data, tx_valid)
// ---------------------------------------------------------------------------
module spi_slave_if #(
  parameter int RX_WIDTH = 10,
  parameter int TX_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_if_if.slave  bus
);

  localparam int RX_CNT_W = $clog2(RX_WIDTH);
  localparam int TX_CNT_W = $clog2(TX_WIDTH + 1);
  localparam logic [RX_CNT_W-1:0] RX_LAST = RX_CNT_W'(RX_WIDTH - 1);
  localparam logic [TX_CNT_W-1:0] TX_LAST = TX_CNT_W'(TX_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t                r_state;
  state_t                w_nextState;

  logic [RX_WIDTH-2:0]   r_rxShift;
  logic [RX_CNT_W-1:0]   r_bitCnt;
  logic                  r_rxDone;
  logic [RX_WIDTH-1:0]   r_rxData;
  logic                  r_rxValid;
  logic                  r_rdAddrSeen;

  logic [TX_WIDTH-1:0]   r_txShift;
  logic [TX_CNT_W-1:0]   r_txCnt;
  logic                  r_txActive;
  logic                  r_txDone;
  logic                  r_miso;

  logic                  w_clear;
  logic                  w_shiftEn;
  logic                  w_rxComplete;
  logic                  w_txLoad;
  logic                  w_txStep;

  // The state register only tracks which kind of frame we are in; all the
  // bit-level bookkeeping lives in the datapath block further down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control strobes. SS_n going high wins over everything in
  // a frame: it throws the frame away and clears the per-frame counters.
  // Inside a frame the receive phase comes first; only once the command word
  // is complete does a read-data frame start looking at tx_valid, and once a
  // byte has gone out (r_txDone) further tx_valid is ignored until SS_n rises.
  always_comb begin
    w_nextState  = r_state;
    w_clear      = 1'b0;
    w_shiftEn    = 1'b0;
    w_rxComplete = 1'b0;
    w_txLoad     = 1'b0;
    w_txStep     = 1'b0;

    case (r_state)
      IDLE: begin
        w_clear = 1'b1;
        if (!bus.SS_n) begin
          w_nextState = CHK_CMD;
          w_clear     = 1'b0;
        end
      end

      CHK_CMD: begin
        if (bus.SS_n) begin
          w_nextState = IDLE;
          w_clear     = 1'b1;
        end else if (!bus.MOSI) begin
          w_nextState = WRITE;
        end else if (!r_rdAddrSeen) begin
          w_nextState = READ_ADD;
        end else begin
          w_nextState = READ_DATA;
        end
      end

      WRITE, READ_ADD, READ_DATA: begin
        if (bus.SS_n) begin
          w_nextState = IDLE;
          w_clear     = 1'b1;
        end else if (!r_rxDone) begin
          w_shiftEn = 1'b1;
          if (r_bitCnt == RX_LAST) begin
            w_rxComplete = 1'b1;
          end
        end else if (r_state == READ_DATA) begin
          if (r_txActive) begin
            w_txStep = 1'b1;
          end else if (!r_txDone && bus.tx_valid) begin
            w_txLoad = 1'b1;
          end
        end
      end

      default: begin
        w_nextState = IDLE;
        w_clear     = 1'b1;
      end
    endcase
  end

  // Datapath. The last command bit is taken straight from MOSI into rx_data
  // so rx_valid is high in the cycle right after that bit was sampled.
  // MISO is registered: the load edge already puts the MSB on the pin, so
  // the byte occupies the TX_WIDTH cycles following the tx_valid edge, and
  // the edge that ends the last bit returns MISO to 0 and retires the
  // pending read address. An aborted shift leaves r_rdAddrSeen alone, so the
  // master can simply retry the read-data frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxShift    <= '0;
      r_bitCnt     <= '0;
      r_rxDone     <= 1'b0;
      r_rxData     <= '0;
      r_rxValid    <= 1'b0;
      r_rdAddrSeen <= 1'b0;
      r_txShift    <= '0;
      r_txCnt      <= '0;
      r_txActive   <= 1'b0;
      r_txDone     <= 1'b0;
      r_miso       <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;

      if (w_clear) begin
        r_bitCnt   <= '0;
        r_rxDone   <= 1'b0;
        r_txCnt    <= '0;
        r_txActive <= 1'b0;
        r_txDone   <= 1'b0;
        r_miso     <= 1'b0;
      end else begin
        if (w_shiftEn) begin
          r_rxShift <= {r_rxShift[RX_WIDTH-3:0], bus.MOSI};
          r_bitCnt  <= r_bitCnt + 1'b1;
        end

        if (w_rxComplete) begin
          r_rxData  <= {r_rxShift, bus.MOSI};
          r_rxValid <= 1'b1;
          r_rxDone  <= 1'b1;
          if (r_state == READ_ADD) begin
            r_rdAddrSeen <= 1'b1;
          end
        end

        if (w_txLoad) begin
          r_miso     <= bus.tx_data[TX_WIDTH-1];
          r_txShift  <= {bus.tx_data[TX_WIDTH-2:0], 1'b0};
          r_txCnt    <= TX_CNT_W'(1);
          r_txActive <= 1'b1;
        end

        if (w_txStep) begin
          if (r_txCnt == TX_LAST) begin
            r_miso       <= 1'b0;
            r_txActive   <= 1'b0;
            r_txDone     <= 1'b1;
            r_rdAddrSeen <= 1'b0;
          end else begin
            r_miso    <= r_txShift[TX_WIDTH-1];
            r_txShift <= {r_txShift[TX_WIDTH-2:0], 1'b0};
            r_txCnt   <= r_txCnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.MISO     = r_miso;
  assign bus.rx_data  = r_rxData;
  assign bus.rx_valid = r_rxValid;

endmodule
